// File: rtl/demux_scan_pkg.sv
// Purpose : shared types and constants for the demux_scan serial-to-parallel distributor.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package demux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int   N_OUT_DEF  = 16;
    localparam logic MODE_ADDR  = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

endpackage

// File: rtl/demux_scan_ctr.sv
// Purpose : sweep slot counter with synchronous clear, increment and terminal-count flag.
// Latency : count changes on the edge after clr/inc; tc is combinational from the count.
// Backpr. : none; inc is ignored once tc is reached, so the count saturates there.
//
// Ports: clk, rst_n (async, active-low), clr, inc, cnt[CNT_W-1:0], tc.
module demux_scan_ctr #(
    parameter int CNT_W = 4,
    parameter int TERM  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == CNT_W'(TERM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_scan.sv
// Purpose : distributes a 1-bit serial stream onto N_OUT outputs (ADDR: addressed write, SWEEP: framed fill).
// Latency : ADDR write lands 1 cycle after acceptance; SWEEP frame publishes on the edge accepting its last beat.
// Backpr. : in_ready drops outside accepting states; a published frame is held until out_valid&out_ready.
//
// Ports: clk, rst_n (async, active-low), mode, start, in_valid/in_ready/in_bit/in_sel/in_en,
//        out_data/out_valid/out_ready, busy, err.
// Build option: define DEMUX_SCAN_PARITY_EN to append an even-parity beat to each SWEEP frame
//        and drive err; otherwise err is constant 0.
module demux_scan
    import demux_scan_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_en,
    output logic [N_OUT-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

`ifdef DEMUX_SCAN_PARITY_EN
    // One extra bit so the counter can name the parity beat at index N_OUT.
    localparam int CNT_W = SEL_W + 1;
    localparam int TERM  = N_OUT;
`else
    localparam int CNT_W = SEL_W;
    localparam int TERM  = N_OUT - 1;
`endif

    localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

    state_t             state_q, state_nxt;
    logic [N_OUT-1:0]   shadow;
    logic [N_OUT-1:0]   pub_data;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   cnt_idx;
    logic               ctr_tc;
    logic               sel_ok;
    logic               in_ready_c;
    logic               ctr_clr, ctr_inc;
    logic               shadow_clr, shadow_wr;
    logic               addr_wr, publish, frame_taken;

    assign cnt_idx = cnt[SEL_W-1:0];
    assign sel_ok  = ({1'b0, in_sel} < N_OUT_W);
    // Held low while reset is asserted, independent of the reset-value state.
    assign in_ready = in_ready_c & rst_n;
    assign busy     = (state_q != IDLE);

    demux_scan_ctr #(
        .CNT_W (CNT_W),
        .TERM  (TERM)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .inc   (ctr_inc),
        .cnt   (cnt),
        .tc    (ctr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        in_ready_c  = 1'b0;
        ctr_clr     = 1'b0;
        ctr_inc     = 1'b0;
        shadow_clr  = 1'b0;
        shadow_wr   = 1'b0;
        addr_wr     = 1'b0;
        publish     = 1'b0;
        frame_taken = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode == MODE_ADDR) begin
                    in_ready_c = 1'b1;
                    addr_wr    = in_valid & in_en & sel_ok;
                end else if (start) begin
                    state_nxt  = COLLECT;
                    ctr_clr    = 1'b1;
                    shadow_clr = 1'b1;
                end
            end
            COLLECT: begin
                if (start) begin
                    // Restart: the beat presented this cycle is refused.
                    ctr_clr    = 1'b1;
                    shadow_clr = 1'b1;
                end else begin
                    in_ready_c = 1'b1;
                    if (in_valid) begin
                        ctr_inc = 1'b1;
`ifdef DEMUX_SCAN_PARITY_EN
                        shadow_wr = !ctr_tc;  // parity beat is not a data slot
`else
                        shadow_wr = 1'b1;
`endif
                        if (ctr_tc) begin
                            publish   = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    frame_taken = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DEMUX_SCAN_PARITY_EN
    // Data slots are already complete when the parity beat arrives.
    assign pub_data = shadow;
`else
    // Last data bit is merged in so the frame publishes on the same edge it arrives.
    always_comb begin
        pub_data          = shadow;
        pub_data[cnt_idx] = in_bit;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (shadow_clr) begin
                shadow <= '0;
            end else if (shadow_wr) begin
                shadow[cnt_idx] <= in_bit;
            end
            if (addr_wr) begin
                out_data[in_sel] <= in_bit;
            end
            if (publish) begin
                out_data  <= pub_data;
                out_valid <= 1'b1;
            end else if (frame_taken) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX_SCAN_PARITY_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (publish) begin
            err_q <= (^shadow) ^ in_bit;
        end else if (frame_taken) begin
            err_q <= 1'b0;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
